// File: rtl/mc10_kbd_pkg.sv
// Shared types and the PS/2 set-2 to MC-10 matrix translation table.
// Matrix cells are addressed as column (CPU strobe A0..A7) and row (sense bit).
package mc10_kbd_pkg;

  localparam int NCOL = 8;
  localparam int NROW = 8;

  localparam logic [2:0] COL_CTRL  = 3'd0;
  localparam logic [2:0] COL_BREAK = 3'd2;
  localparam logic [2:0] COL_SHIFT = 3'd7;
  localparam logic [2:0] ROW_MOD   = 3'd6;

  typedef enum logic [1:0] {K_NORMAL, K_SHIFT, K_SYMBOL} key_kind_e;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_APPLY} kbd_state_e;

  // For K_SHIFT entries col[0] selects the right-hand shift flag.
  typedef struct packed {
    logic       valid;
    key_kind_e  kind;
    logic [2:0] col;
    logic [2:0] row;
    logic [2:0] col_s;
    logic [2:0] row_s;
    logic       fs;
    logic       fns;
    logic       fs_s;
    logic       fns_s;
  } kbd_entry_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] col;
    logic [2:0] row;
    logic       fs;
    logic       fns;
  } kbd_slot_t;

  function automatic kbd_entry_t e_norm(input logic [2:0] c, input logic [2:0] r);
    kbd_entry_t e;
    e = '0;
    e.valid = 1'b1;
    e.kind  = K_NORMAL;
    e.col   = c;
    e.row   = r;
    return e;
  endfunction

  function automatic kbd_entry_t e_shift(input logic right);
    kbd_entry_t e;
    e = '0;
    e.valid = 1'b1;
    e.kind  = K_SHIFT;
    e.col   = {2'b00, right};
    return e;
  endfunction

  function automatic kbd_entry_t e_sym(input logic [2:0] c, input logic [2:0] r,
                                       input logic f, input logic fn,
                                       input logic [2:0] cs, input logic [2:0] rs,
                                       input logic f_s, input logic fn_s);
    kbd_entry_t e;
    e.valid = 1'b1;
    e.kind  = K_SYMBOL;
    e.col   = c;
    e.row   = r;
    e.col_s = cs;
    e.row_s = rs;
    e.fs    = f;
    e.fns   = fn;
    e.fs_s  = f_s;
    e.fns_s = fn_s;
    return e;
  endfunction

  // Index is {E0-extended, scancode}; unlisted codes return an invalid entry.
  function automatic kbd_entry_t kbd_lookup(input logic [8:0] idx);
    case (idx)
      9'h01C: return e_norm(3'd1, 3'd0);  // A
      9'h032: return e_norm(3'd2, 3'd0);
      9'h021: return e_norm(3'd3, 3'd0);
      9'h023: return e_norm(3'd4, 3'd0);
      9'h024: return e_norm(3'd5, 3'd0);
      9'h02B: return e_norm(3'd6, 3'd0);
      9'h034: return e_norm(3'd7, 3'd0);
      9'h033: return e_norm(3'd0, 3'd1);  // H
      9'h043: return e_norm(3'd1, 3'd1);
      9'h03B: return e_norm(3'd2, 3'd1);
      9'h042: return e_norm(3'd3, 3'd1);
      9'h04B: return e_norm(3'd4, 3'd1);
      9'h03A: return e_norm(3'd5, 3'd1);
      9'h031: return e_norm(3'd6, 3'd1);
      9'h044: return e_norm(3'd7, 3'd1);
      9'h04D: return e_norm(3'd0, 3'd2);  // P
      9'h015: return e_norm(3'd1, 3'd2);
      9'h02D: return e_norm(3'd2, 3'd2);
      9'h01B: return e_norm(3'd3, 3'd2);
      9'h02C: return e_norm(3'd4, 3'd2);
      9'h03C: return e_norm(3'd5, 3'd2);
      9'h02A: return e_norm(3'd6, 3'd2);
      9'h01D: return e_norm(3'd7, 3'd2);
      9'h022: return e_norm(3'd0, 3'd3);  // X
      9'h035: return e_norm(3'd1, 3'd3);
      9'h01A: return e_norm(3'd2, 3'd3);
      9'h05A: return e_norm(3'd6, 3'd3);  // ENTER
      9'h15A: return e_norm(3'd6, 3'd3);
      9'h029: return e_norm(3'd7, 3'd3);  // SPACE
      9'h045: return e_norm(3'd0, 3'd4);  // 0
      9'h016: return e_norm(3'd1, 3'd4);
      9'h01E: return e_norm(3'd2, 3'd4);
      9'h026: return e_norm(3'd3, 3'd4);
      9'h025: return e_norm(3'd4, 3'd4);
      9'h02E: return e_norm(3'd5, 3'd4);
      9'h036: return e_norm(3'd6, 3'd4);
      9'h03D: return e_norm(3'd7, 3'd4);
      9'h03E: return e_norm(3'd0, 3'd5);  // 8
      9'h046: return e_norm(3'd1, 3'd5);
      9'h014: return e_norm(COL_CTRL, ROW_MOD);
      9'h114: return e_norm(COL_CTRL, ROW_MOD);
      9'h076: return e_norm(COL_BREAK, ROW_MOD);
      9'h012: return e_shift(1'b0);
      9'h059: return e_shift(1'b1);
      // PC symbol keys: {unshifted cell, flags}, {shifted cell, flags}
      9'h055: return e_sym(3'd5, 3'd5, 1'b1, 1'b0, 3'd3, 3'd5, 1'b1, 1'b0);  // = +
      9'h04E: return e_sym(3'd5, 3'd5, 1'b0, 1'b1, 3'd5, 3'd5, 1'b0, 1'b1);  // -
      9'h04C: return e_sym(3'd3, 3'd5, 1'b0, 1'b1, 3'd2, 3'd5, 1'b0, 1'b1);  // ; :
      9'h052: return e_sym(3'd7, 3'd4, 1'b1, 1'b0, 3'd2, 3'd4, 1'b1, 1'b0);  // ' "
      9'h041: return e_sym(3'd4, 3'd5, 1'b0, 1'b1, 3'd4, 3'd5, 1'b1, 1'b0);  // , <
      9'h049: return e_sym(3'd6, 3'd5, 1'b0, 1'b1, 3'd6, 3'd5, 1'b1, 1'b0);  // . >
      9'h04A: return e_sym(3'd7, 3'd5, 1'b0, 1'b1, 3'd7, 3'd5, 1'b1, 1'b0);  // / ?
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/mc10_kbd_rom.sv
// Registered translation lookup: one clock from address to entry.
module mc10_kbd_rom
  import mc10_kbd_pkg::*;
(
  input  logic       clk_sys,
  input  logic [8:0] addr,
  output kbd_entry_t data
);

  always_ff @(posedge clk_sys) begin
    data <= kbd_lookup(addr);
  end

endmodule

// File: rtl/mc10_keymatrix.sv
// PS/2 event decoder feeding the MC-10 8x8 key matrix; the CPU strobes
// columns (active low) and reads back registered active-low row sense.
module mc10_keymatrix
  import mc10_kbd_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [7:0]  kb_col,
  output logic [7:0]  kb_row,
  output logic        shift_forced
);

  kbd_state_e            state;
  logic [NCOL-1:0][NROW-1:0] km;
  logic [NCOL-1:0][NROW-1:0] km_eff;
  logic                  lsh, rsh, last_tog;
  logic                  pressed_q, ext_q;
  logic [7:0]            code_q;
  kbd_slot_t             slot;
  kbd_entry_t            rom_q;
  logic [NROW-1:0]       row_any;
  logic                  shifted;
  logic [2:0]            sym_col, sym_row;
  logic                  sym_fs, sym_fns;

  mc10_kbd_rom u_rom (
    .clk_sys (clk_sys),
    .addr    ({ext_q, code_q}),
    .data    (rom_q)
  );

  assign shifted = lsh | rsh;
  assign sym_col = shifted ? rom_q.col_s : rom_q.col;
  assign sym_row = shifted ? rom_q.row_s : rom_q.row;
  assign sym_fs  = shifted ? rom_q.fs_s  : rom_q.fs;
  assign sym_fns = shifted ? rom_q.fns_s : rom_q.fns;

  assign shift_forced = slot.valid & (slot.fs | slot.fns);

  // A held symbol key overrides both physical shifts and a matrix SHIFT.
  always_comb begin
    km_eff = km;
    if (slot.valid & slot.fs)
      km_eff[COL_SHIFT][ROW_MOD] = 1'b1;
    else if (slot.valid & slot.fns)
      km_eff[COL_SHIFT][ROW_MOD] = 1'b0;
    else
      km_eff[COL_SHIFT][ROW_MOD] = shifted | km[COL_SHIFT][ROW_MOD];
    row_any = '0;
    for (int c = 0; c < NCOL; c++)
      if (!kb_col[c]) row_any = row_any | km_eff[c];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= S_IDLE;
      km        <= '0;
      lsh       <= 1'b0;
      rsh       <= 1'b0;
      slot      <= '0;
      last_tog  <= ps2_key[10];
      pressed_q <= 1'b0;
      ext_q     <= 1'b0;
      code_q    <= 8'h00;
      kb_row    <= 8'hFF;
    end else begin
      kb_row <= ~row_any | 8'h80;
      case (state)
        S_IDLE: begin
          if (ps2_key[10] != last_tog) begin
            last_tog  <= ps2_key[10];
            pressed_q <= ps2_key[9];
            ext_q     <= ps2_key[8];
            code_q    <= ps2_key[7:0];
            state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: state <= S_APPLY;
        S_APPLY: begin
          state <= S_IDLE;
          if (rom_q.valid) begin
            case (rom_q.kind)
              K_SHIFT: begin
                if (rom_q.col[0]) rsh <= pressed_q;
                else              lsh <= pressed_q;
              end
              K_NORMAL: km[rom_q.col][rom_q.row] <= pressed_q;
              K_SYMBOL: begin
                // The break clears the slot's cell: shift may have changed since the make.
                if (pressed_q) begin
                  if (slot.valid) km[slot.col][slot.row] <= 1'b0;
                  km[sym_col][sym_row] <= 1'b1;
                  slot <= {1'b1, sym_col, sym_row, sym_fs, sym_fns};
                end else if (slot.valid) begin
                  km[slot.col][slot.row] <= 1'b0;
                  slot.valid <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc10_keymatrix.sv
// Directed bench: stimulus queues expected {kb_row, shift_forced}; a monitor
// pops and compares on the falling edge after each expectation is queued.
module tb_mc10_keymatrix;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [7:0]  kb_col;
  logic [7:0]  kb_row;
  logic        shift_forced;

  typedef struct {
    string      name;
    logic [7:0] row;
    logic       sf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  mc10_keymatrix dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_key      (ps2_key),
    .kb_col       (kb_col),
    .kb_row       (kb_row),
    .shift_forced (shift_forced)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (kb_row !== e.row || shift_forced !== e.sf) begin
        errors++;
        $display("FAIL %s: got kb_row=%h shift_forced=%b, want kb_row=%h shift_forced=%b",
                 e.name, kb_row, shift_forced, e.row, e.sf);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [7:0] row, input logic sf);
    exp_t e;
    e.name = name;
    e.row  = row;
    e.sf   = sf;
    q.push_back(e);
  endtask

  task automatic tog(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
    tog(pressed, ext, code);
    step(6);
  endtask

  task automatic look(input string name, input logic [7:0] col, input logic [7:0] row,
                      input logic sf);
    kb_col = col;
    step(2);
    expect_out(name, row, sf);
  endtask

  initial begin
    reset   = 1'b1;
    kb_col  = 8'h00;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h1C};
    step(4);
    expect_out("reset_hold", 8'hFF, 1'b0);
    reset = 1'b0;
    step(6);
    expect_out("no_spurious_event", 8'hFF, 1'b0);

    // 'A' make: visible on the 4th edge after the toggle
    kb_col = 8'hFD;
    tog(1'b1, 1'b0, 8'h1C);
    step(3);
    expect_out("a_latency3", 8'hFF, 1'b0);
    step(1);
    expect_out("a_latency4", 8'hFE, 1'b0);
    look("a_other_col", 8'hFE, 8'hFF, 1'b0);
    send(1'b0, 1'b0, 8'h1C);
    look("a_break", 8'hFD, 8'hFF, 1'b0);

    // '=' without PC shift -> SHIFT + '-'
    send(1'b1, 1'b0, 8'h55);
    look("eq_cell", 8'hDF, 8'hDF, 1'b1);
    look("eq_shift", 8'h7F, 8'hBF, 1'b1);
    send(1'b0, 1'b0, 8'h55);
    look("eq_break_cell", 8'hDF, 8'hFF, 1'b0);
    look("eq_break_shift", 8'h7F, 8'hFF, 1'b0);

    // left shift held: '-' suppresses SHIFT, '+' maps to SHIFT + ';'
    send(1'b1, 1'b0, 8'h12);
    look("lsh_only", 8'h7F, 8'hBF, 1'b0);
    send(1'b1, 1'b0, 8'h4E);
    look("minus_noshift", 8'h7F, 8'hFF, 1'b1);
    look("minus_cell", 8'hDF, 8'hDF, 1'b1);
    send(1'b0, 1'b0, 8'h4E);
    look("minus_break", 8'h7F, 8'hBF, 1'b0);
    send(1'b1, 1'b0, 8'h55);
    look("plus_cell", 8'hF7, 8'hDF, 1'b1);
    look("plus_not_minus", 8'hDF, 8'hFF, 1'b1);
    send(1'b0, 1'b0, 8'h12);
    look("plus_shift_kept", 8'h7F, 8'hBF, 1'b1);
    send(1'b0, 1'b0, 8'h55);
    look("plus_break_cell", 8'hF7, 8'hFF, 1'b0);
    look("plus_break_shift", 8'h7F, 8'hFF, 1'b0);

    // second symbol make replaces the first slot
    send(1'b1, 1'b0, 8'h4C);
    look("semi_cell", 8'hF7, 8'hDF, 1'b1);
    send(1'b1, 1'b0, 8'h55);
    look("replace_old_clear", 8'hF7, 8'hFF, 1'b1);
    look("replace_new_cell", 8'hDF, 8'hDF, 1'b1);
    look("replace_shift", 8'h7F, 8'hBF, 1'b1);
    send(1'b0, 1'b0, 8'h55);
    look("replace_break", 8'hDF, 8'hFF, 1'b0);
    send(1'b0, 1'b0, 8'h4C);
    look("break_empty_slot", 8'h00, 8'hFF, 1'b0);

    // multi-column and ignored events
    send(1'b1, 1'b0, 8'h1C);
    send(1'b1, 1'b0, 8'h5A);
    look("a_enter_all_cols", 8'h00, 8'hF6, 1'b0);
    send(1'b1, 1'b0, 8'h7E);
    look("unmapped_code", 8'h00, 8'hF6, 1'b0);
    ps2_key = {ps2_key[10], 1'b0, 1'b0, 8'h1C};
    step(6);
    look("no_toggle_repeat", 8'h00, 8'hF6, 1'b0);
    send(1'b1, 1'b1, 8'h29);
    look("ext_unmapped", 8'h7F, 8'hFF, 1'b0);

    // reset lands on the APPLY cycle of a new event
    kb_col = 8'h00;
    tog(1'b1, 1'b0, 8'h16);
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    expect_out("reset_mid_apply", 8'hFF, 1'b0);
    step(6);
    expect_out("matrix_empty_after_reset", 8'hFF, 1'b0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk_sys);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
